// File: rtl/tia_pkg.sv
// Shared constants for the TIA framebuffer: VGA 640x480@60 timing, the source line
// width, the pipeline sideband struct and the 128-entry NTSC palette.
package tia_pkg;

  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_TOTAL      = 10'd800;
  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;
  localparam logic [9:0] V_TOTAL      = 10'd525;
  localparam logic [7:0] LINE_W       = 8'd160;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // Index is {hue[3:0], luma[2:0]}.
  localparam logic [23:0] NTSC_PALETTE [128] = '{
    24'h000000, 24'h4a4a4a, 24'h6f6f6f, 24'h8e8e8e, 24'haaaaaa, 24'hc0c0c0, 24'hd6d6d6, 24'hececec,
    24'h484800, 24'h69690f, 24'h86861d, 24'ha2a22a, 24'hbbbb35, 24'hd2d240, 24'he8e84a, 24'hfcfc54,
    24'h7c2c00, 24'h904811, 24'ha26221, 24'hb47a30, 24'hc3903d, 24'hd2a44a, 24'hdfb755, 24'hecc860,
    24'h901c00, 24'ha33915, 24'hb55328, 24'hc66c3a, 24'hd5824a, 24'he39759, 24'hf0aa67, 24'hfcbc74,
    24'h940000, 24'ha71a1a, 24'hb83232, 24'hc84848, 24'hd65c5c, 24'he46f6f, 24'hf08080, 24'hfc9090,
    24'h840064, 24'h97197a, 24'ha8308f, 24'hb846a2, 24'hc659b3, 24'hd46cc3, 24'he07cd2, 24'hec8ce0,
    24'h500084, 24'h68199a, 24'h7d30ad, 24'h9246c0, 24'ha459d0, 24'hb56ce0, 24'hc57cee, 24'hd48cfc,
    24'h140090, 24'h331aa3, 24'h4e32b5, 24'h6848c6, 24'h7f5cd5, 24'h956fe3, 24'ha980f0, 24'hbc90fc,
    24'h000094, 24'h181aa7, 24'h2d32b8, 24'h4248c8, 24'h545cd6, 24'h656fe4, 24'h7580f0, 24'h8490fc,
    24'h001c88, 24'h183b9d, 24'h2d57b0, 24'h4272c2, 24'h548ad2, 24'h65a0e1, 24'h75b5ef, 24'h84c8fc,
    24'h003064, 24'h185080, 24'h2d6d98, 24'h4288b0, 24'h54a0c5, 24'h65b7d9, 24'h75cceb, 24'h84e0fc,
    24'h004030, 24'h18624e, 24'h2d8169, 24'h429e82, 24'h54b899, 24'h65d1ae, 24'h75e7c2, 24'h84fcd4,
    24'h004400, 24'h1a661a, 24'h328432, 24'h48a048, 24'h5cba5c, 24'h6fd26f, 24'h80e880, 24'h90fc90,
    24'h143c00, 24'h355f18, 24'h527e2d, 24'h6e9c42, 24'h87b754, 24'h9ed065, 24'hb4e775, 24'hc8fc84,
    24'h303800, 24'h505916, 24'h6d7629, 24'h88923c, 24'ha0ab4d, 24'hb7c25d, 24'hccd86c, 24'he0ec7a,
    24'h482c00, 24'h694d14, 24'h866a26, 24'ha28638, 24'hbb9f47, 24'hd2b656, 24'he8cc63, 24'hfce070
  };

  function automatic logic [15:0] pix_addr(input logic [7:0] x, input logic [8:0] y);
    return 16'(y) * 16'(LINE_W) + 16'(x);
  endfunction

endpackage

// File: rtl/tia_framebuffer_if.sv
// Signal bundle for the framebuffer: TIA write side and scaled VGA output side.
interface tia_framebuffer_if;
  // vid_wr and pix_en are strobes with no backpressure: every cycle vid_wr is high is
  // exactly one write, every cycle pix_en is high moves the display on by one pixel.
  logic        vid_wr;
  logic [15:0] vid_addr;
  logic [6:0]  vid;
  logic        pix_en;
  logic [23:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame;

  modport master (output vid_wr, vid_addr, vid, pix_en,
                  input  rgb, hsync, vsync, de, frame);
  modport slave  (input  vid_wr, vid_addr, vid, pix_en,
                  output rgb, hsync, vsync, de, frame);
endinterface

// File: rtl/ntsc_palette.sv
// Final pipeline stage: registered TIA colour index in, registered 24-bit RGB out.
module ntsc_palette
  import tia_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        de,
  input  logic [6:0]  idx,
  output logic [23:0] rgb
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb <= '0;
    end else if (en) begin
      rgb <= de ? NTSC_PALETTE[idx] : 24'h000000;
    end
  end

endmodule

// File: rtl/tia_framebuffer.sv
// TIA 160x240 framebuffer scanned out as 640x480 VGA (4x horizontal, 2x vertical).
// Optional macro TIA_FB_SCANLINES_EN halves every RGB component on odd output lines.
module tia_framebuffer
  import tia_pkg::*;
#(
  parameter int unsigned FB_DEPTH       = 38400,
  parameter logic [9:0]  V_ACTIVE_LINES = V_ACTIVE,
  parameter logic [9:0]  V_SYNC_BEGIN   = V_SYNC_START,
  parameter logic [9:0]  V_SYNC_STOP    = V_SYNC_END,
  parameter logic [9:0]  V_TOTAL_LINES  = V_TOTAL
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vid_wr_i,
  input  logic [15:0] vid_addr_i,
  input  logic [6:0]  vid_i,
  input  logic        pix_en_i,
  output logic [23:0] rgb_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        frame_o
);

  logic [9:0]  h;
  logic [9:0]  v;
  logic        h_wrap;
  logic        v_wrap;
  logic        active;
  logic        frame_q;
  logic [15:0] addr_q;
  logic [6:0]  rd_q;
  logic [23:0] rgb_q;
  sync_t       s0, s1, s2;
  logic [6:0]  mem [FB_DEPTH];

  assign h_wrap = (h == H_TOTAL - 10'd1);
  assign v_wrap = (v == V_TOTAL_LINES - 10'd1);
  assign active = (h < H_ACTIVE) && (v < V_ACTIVE_LINES);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h       <= '0;
      v       <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= pix_en_i && h_wrap && v_wrap;
      if (pix_en_i) begin
        if (h_wrap) begin
          h <= '0;
          v <= v_wrap ? 10'd0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  // Stage 0: read address plus syncs decoded from the live counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      s0     <= SYNC_IDLE;
    end else if (pix_en_i) begin
      addr_q   <= active ? pix_addr(h[9:2], v[9:1]) : 16'd0;
      s0.de    <= active;
      s0.hsync <= !((h >= H_SYNC_START) && (h < H_SYNC_END));
      s0.vsync <= !((v >= V_SYNC_BEGIN) && (v < V_SYNC_STOP));
    end
  end

  // Stage 1: writes are independent of the display; a same-address read sees old data.
  always_ff @(posedge clk_i) begin
    if (vid_wr_i && (32'(vid_addr_i) < FB_DEPTH)) begin
      mem[vid_addr_i] <= vid_i;
    end
    if (rst_i) begin
      rd_q <= '0;
      s1   <= SYNC_IDLE;
      s2   <= SYNC_IDLE;
    end else if (pix_en_i) begin
      rd_q <= mem[addr_q];
      s1   <= s0;
      s2   <= s1;
    end
  end

  ntsc_palette u_palette (
    .clk (clk_i),
    .rst (rst_i),
    .en  (pix_en_i),
    .de  (s1.de),
    .idx (rd_q),
    .rgb (rgb_q)
  );

`ifdef TIA_FB_SCANLINES_EN
  logic [2:0] odd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      odd_q <= '0;
    end else if (pix_en_i) begin
      odd_q <= {odd_q[1:0], v[0]};
    end
  end

  assign rgb_o = odd_q[2] ? {1'b0, rgb_q[23:17], 1'b0, rgb_q[15:9], 1'b0, rgb_q[7:1]} : rgb_q;
`else
  assign rgb_o = rgb_q;
`endif

  assign de_o    = s2.de;
  assign hsync_o = s2.hsync;
  assign vsync_o = s2.vsync;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_tia_framebuffer.sv
// Directed bench for tia_framebuffer; the vertical geometry is shortened to 15 lines
// (8 active, sync on lines 10-11) so a frame is 12000 pixel enables.
module tb_tia_framebuffer;

  localparam int FRAME_PIX = 800 * 15;
  localparam logic [23:0] C_0E = 24'he8e84a;
  localparam logic [23:0] C_10 = 24'h7c2c00;
  localparam logic [23:0] C_44 = 24'h545cd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  int   k = 0;
  int   hs_lo = 0;
  int   vs_lo = 0;
  int   frames = 0;
  int   frame_k = 0;

  always #5 clk = ~clk;

  tia_framebuffer_if vif ();

  tia_framebuffer #(
    .FB_DEPTH       (38400),
    .V_ACTIVE_LINES (10'd8),
    .V_SYNC_BEGIN   (10'd10),
    .V_SYNC_STOP    (10'd12),
    .V_TOTAL_LINES  (10'd15)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .vid_wr_i   (vif.vid_wr),
    .vid_addr_i (vif.vid_addr),
    .vid_i      (vif.vid),
    .pix_en_i   (vif.pix_en),
    .rgb_o      (vif.rgb),
    .hsync_o    (vif.hsync),
    .vsync_o    (vif.vsync),
    .de_o       (vif.de),
    .frame_o    (vif.frame)
  );

`ifdef TIA_FB_SCANLINES_EN
  function automatic logic [23:0] dim(input logic [23:0] c);
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
  endfunction
`else
  function automatic logic [23:0] dim(input logic [23:0] c);
    return c;
  endfunction
`endif

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pix_step();
    vif.pix_en = 1'b1;
    clk_step();
    k++;
    if (!vif.hsync) hs_lo++;
    if (!vif.vsync) vs_lo++;
    if (vif.frame) begin
      frames++;
      frame_k = k;
    end
  endtask

  task automatic pix_run(input int target);
    while (k < target) pix_step();
  endtask

  task automatic tia_write(input logic [15:0] addr, input logic [6:0] data);
    vif.vid_wr   = 1'b1;
    vif.vid_addr = addr;
    vif.vid      = data;
    clk_step();
    vif.vid_wr   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"},   vif.rgb, 24'h000000);
    check({tag, "_de"},    24'(vif.de), 24'd0);
    check({tag, "_hsync"}, 24'(vif.hsync), 24'd1);
    check({tag, "_vsync"}, 24'(vif.vsync), 24'd1);
    check({tag, "_frame"}, 24'(vif.frame), 24'd0);
  endtask

  initial begin
    vif.vid_wr   = 1'b0;
    vif.vid_addr = '0;
    vif.vid      = '0;
    vif.pix_en   = 1'b0;
    @(negedge clk);
    repeat (2) clk_step();
    check_reset_outputs("reset");

    // Framebuffer writes land while reset is still held.
    tia_write(16'd0, 7'h0E);
    tia_write(16'd1, 7'h10);
    tia_write(16'd2, 7'h44);
    tia_write(16'd38400, 7'h7F);
    tia_write(16'd65535, 7'h7F);

    rst = 1'b0;
    pix_step();
    pix_step();
    check("fill_de", 24'(vif.de), 24'd0);
    hs_lo = 0; vs_lo = 0; frames = 0;

    pix_step();
    check("px0_rgb", vif.rgb, C_0E);
    check("px0_de", 24'(vif.de), 24'd1);
    pix_step();
    check("px1_rgb", vif.rgb, C_0E);
    pix_step();
    check("px2_rgb", vif.rgb, C_0E);

    // Edge 6 reads addr 1 for pixel 4 while the TIA rewrites it.
    vif.vid_wr = 1'b1; vif.vid_addr = 16'd1; vif.vid = 7'h44;
    pix_step();
    vif.vid_wr = 1'b0;
    check("px3_rgb", vif.rgb, C_0E);
    pix_step();
    check("rdw_old_rgb", vif.rgb, C_10);

    vif.pix_en = 1'b0;
    repeat (3) clk_step();
    check("hold_rgb", vif.rgb, C_10);
    check("hold_de", 24'(vif.de), 24'd1);

    pix_run(11);
    check("px8_rgb", vif.rgb, C_44);
    pix_run(642);
    check("h639_de", 24'(vif.de), 24'd1);
    pix_run(643);
    check("h640_de", 24'(vif.de), 24'd0);
    check("h640_rgb", vif.rgb, 24'h000000);
    pix_run(658);
    check("h655_hsync", 24'(vif.hsync), 24'd1);
    pix_run(659);
    check("h656_hsync", 24'(vif.hsync), 24'd0);
    pix_run(754);
    check("h751_hsync", 24'(vif.hsync), 24'd0);
    pix_run(755);
    check("h752_hsync", 24'(vif.hsync), 24'd1);
    pix_run(803);
    check("line1_rgb", vif.rgb, dim(C_0E));
    pix_run(5603);
    check("line7_de", 24'(vif.de), 24'd1);
    pix_run(6403);
    check("line8_de", 24'(vif.de), 24'd0);
    pix_run(FRAME_PIX);
    check("frame_pulse", 24'(vif.frame), 24'd1);
    pix_run(FRAME_PIX + 1);
    check("frame_width", 24'(vif.frame), 24'd0);
    pix_run(FRAME_PIX + 2);
    check("hsync_low_count", 24'(hs_lo), 24'd1440);
    check("vsync_low_count", 24'(vs_lo), 24'd1600);
    check("frames_in_frame", 24'(frames), 24'd1);
    check("frame_period", 24'(frame_k), 24'(FRAME_PIX));
    pix_run(FRAME_PIX + 3);
    check("f2_px0_rgb", vif.rgb, C_0E);
    pix_run(FRAME_PIX + 7);
    check("rdw_new_rgb", vif.rgb, C_44);

    // Reset at h=300, v=5 for two cycles with pix_en still high.
    pix_run(FRAME_PIX + 5 * 800 + 300);
    rst = 1'b1;
    clk_step();
    check_reset_outputs("midline");
    clk_step();
    rst = 1'b0;
    k = 0; frames = 0; frame_k = 0;
    pix_run(3);
    check("restart_rgb", vif.rgb, C_0E);
    check("restart_de", 24'(vif.de), 24'd1);
    pix_run(FRAME_PIX - 1);
    check("no_early_frame", 24'(frames), 24'd0);
    pix_run(FRAME_PIX);
    check("rst_frame_pulse", 24'(vif.frame), 24'd1);
    check("rst_frame_k", 24'(frame_k), 24'(FRAME_PIX));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tia_framebuffer.md
TIA_FRAMEBUFFER -- requirements
Module: tia_framebuffer

Interface
REQ-001 SHALL declare parameter FB_DEPTH, default 38400, the number of framebuffer entries (160x240).
REQ-002 SHALL declare port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL declare port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL declare port vid_wr_i, input, 1 bit: pixel write strobe from the TIA.
REQ-005 SHALL declare port vid_addr_i, input, 16 bits: pixel address, computed as y*160+x.
REQ-006 SHALL declare port vid_i, input, 7 bits: TIA colour index (luma/hue).
REQ-007 SHALL declare port pix_en_i, input, 1 bit: display pixel-clock enable, one pulse per output pixel.
REQ-008 SHALL declare port rgb_o, output, 24 bits: {R,G,B} pixel.
REQ-009 SHALL declare ports hsync_o and vsync_o, outputs, 1 bit each: active-low syncs.
REQ-010 SHALL declare port de_o, output, 1 bit: data enable.
REQ-011 SHALL declare port frame_o, output, 1 bit: one-cycle pulse at the start of each output frame.

Function
REQ-012 SHALL, on any clk_i edge with vid_wr_i=1 and vid_addr_i<FB_DEPTH, write vid_i into mem[vid_addr_i]; writes with vid_addr_i>=FB_DEPTH SHALL be ignored.
REQ-013 SHALL advance the horizontal counter h (0..799) only on cycles with pix_en_i=1, wrapping 799->0, and SHALL advance the vertical counter v (0..524) on that wrap, wrapping 524->0.
REQ-014 SHALL treat the display as active when h<640 and v<480, and SHALL use source x=h>>2 (4x horizontal) and y=v>>1 (2x vertical) to form read address y*160+x.
REQ-015 SHALL implement a 3-stage pipeline advanced by pix_en_i: address register, then RAM read, then palette lookup; de, hsync and vsync SHALL be delayed by the same 3 stages so they stay aligned with rgb_o.
REQ-016 SHALL drive hsync_o=0 when 656<=h<=751 and vsync_o=0 when 490<=v<=491, both measured at pipeline stage 0.
REQ-017 SHALL drive rgb_o=0 whenever the delayed de is 0.
REQ-018 SHALL return the old data when a read and a write hit the same address in the same cycle.
REQ-019 SHALL pulse frame_o for exactly one clk_i cycle when the counters step from (799,524) to (0,0).
REQ-020 SHALL hold all outputs stable on cycles with pix_en_i=0.

Reset
REQ-021 SHALL, while rst_i=1, set h=0, v=0, clear the pipeline, and drive rgb_o=0, de_o=0, hsync_o=1, vsync_o=1, frame_o=0.
REQ-022 SHALL NOT clear framebuffer contents on reset, and SHALL still accept TIA writes while rst_i=1.
REQ-023 SHALL, on reset asserted mid-line, restart the output frame at (0,0) on the first pix_en_i after release.

Configuration
REQ-024 SHALL define macro TIA_FB_SCANLINES_EN: when it is defined, each RGB component on odd v lines SHALL be halved (logical shift right by 1); when it is undefined, odd and even lines SHALL be identical.

Structure
REQ-025 SHALL place the 128-entry x 24-bit NTSC palette constant and the timing constants (640/656/752/800, 480/490/492/525, line width 160) in the shared package tia_pkg.
REQ-026 SHALL implement the palette lookup as a separate sub-module, ntsc_palette, with a registered 7-bit index in and 24-bit RGB out.

Verification
REQ-027 SHALL cover this scenario: write vid_i=7'h0E at addr 0, with pix_en_i held high after reset -> on the 3rd pix_en_i rgb_o=palette[0x0E] and de_o=1, for the next 4 pixels and both of lines 0 and 1.
REQ-028 SHALL cover this scenario: write at addr 38400 and at addr 65535 -> mem unchanged and a readback of addr 0 still returns its prior value.
REQ-029 SHALL cover this scenario: count pix_en_i over one frame -> hsync_o low for 96 pixels per line, vsync_o low for 2 lines, frame_o pulses once every 420000 pix_en_i.
REQ-030 SHALL cover this scenario: simultaneous write of 7'h44 and read of the same address holding 7'h10 -> the pixel shows palette[0x10], and the following frame shows palette[0x44].
REQ-031 SHALL cover this scenario: assert rst_i at h=300, v=200 for 2 cycles -> outputs take reset values and the next frame_o comes 420000 pix_en_i after release; framebuffer contents are retained.
REQ-032 SHALL cover this scenario: with TIA_FB_SCANLINES_EN defined and a palette entry of 24'hFF8040 -> line 0 shows FF8040 and line 1 shows 7F4020.
